// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus: FSM state encoding, access size
// codes, the default error read-data pattern and the slave index ceiling.
package periph_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_ERR    = 3'd2,
    ST_DONE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

  localparam int MAX_SLAVES = 16;

endpackage

// File: rtl/periph_bus_decode.sv
// Combinational slave decode: extracts the slave-index field from an address
// and flags whether it selects a populated slave port. Shared with the DMA
// master port, so it carries no state.
module periph_bus_decode
  import periph_bus_pkg::*;
#(
  parameter int N_SLAVES = 4,
  parameter int IDX_LO   = 12,
  parameter int IDX_BITS = 4
) (
  input  logic [31:0]         addr,
  output logic [IDX_BITS-1:0] idx,
  output logic                valid
);

  assign idx   = addr[IDX_LO +: IDX_BITS];
  assign valid = (32'(idx) < 32'(N_SLAVES));

endmodule

// File: rtl/periph_bus.sv
// Peripheral bus: one CPU master port fanned out to N_SLAVES slave ports.
// One transaction at a time; unmapped addresses end with an error response.
// Optional watchdog on stalled slaves: define PERIPH_BUS_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | waiting for m_rd_i / m_we_i, request latched on acceptance
//   ACCESS | strobe to the selected slave, waiting for its ack
//   ERR    | decode miss, load error data and error address
//   DONE   | one-cycle m_ack_o (and err_o if the transaction failed)
//   HOLD   | wait for the master to drop its request lines
module periph_bus
  import periph_bus_pkg::*;
#(
  parameter int          N_SLAVES = 4,
  parameter int          IDX_LO   = 12,
  parameter int          IDX_BITS = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             m_addr_i,
  input  logic [31:0]             m_data_i,
  output logic [31:0]             m_data_o,
  input  logic [1:0]              m_sel_i,
  input  logic                    m_rd_i,
  input  logic                    m_we_i,
  output logic                    m_ack_o,
  output logic [32*N_SLAVES-1:0]  s_addr_o,
  output logic [32*N_SLAVES-1:0]  s_data_o,
  input  logic [32*N_SLAVES-1:0]  s_data_i,
  output logic [2*N_SLAVES-1:0]   s_sel_o,
  output logic [N_SLAVES-1:0]     s_rd_o,
  output logic [N_SLAVES-1:0]     s_we_o,
  input  logic [N_SLAVES-1:0]     s_ack_i,
  output logic                    err_o,
  output logic [31:0]             err_addr_o
);

  state_t              state_q, state_d;
  logic [31:0]         addr_q, data_q, m_data_q, err_addr_q;
  logic [1:0]          sel_q;
  logic                we_q, strobe_q, err_q;
  logic [IDX_BITS-1:0] idx_q, dec_idx;
  logic                dec_valid, req, ack_sel, ack_hit, timeout_hit;
  logic [31:0]         rdata_sel;

  periph_bus_decode #(
    .N_SLAVES (N_SLAVES),
    .IDX_LO   (IDX_LO),
    .IDX_BITS (IDX_BITS)
  ) u_decode (
    .addr  (m_addr_i),
    .idx   (dec_idx),
    .valid (dec_valid)
  );

  assign req = m_rd_i | m_we_i;

  // Pick the ack and read data of the latched slave; other slots are ignored.
  always_comb begin
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (32'(idx_q) == 32'(k)) begin
        ack_sel   = s_ack_i[k];
        rdata_sel = s_data_i[32*k +: 32];
      end
    end
  end

  // An ack only counts once our strobe is actually on the wire.
  assign ack_hit = (state_q == ST_ACCESS) && strobe_q && ack_sel;

`ifdef PERIPH_BUS_TIMEOUT_EN
  logic [15:0] cnt_q;

  // Watchdog: counts ACCESS cycles, cleared whenever we are elsewhere.
  always_ff @(posedge clk) begin
    if (rst || state_q != ST_ACCESS) cnt_q <= '0;
    else                             cnt_q <= cnt_q + 16'd1;
  end

  // Fires at the end of the TIMEOUT-th ACCESS cycle; a same-cycle ack wins.
  assign timeout_hit = (state_q == ST_ACCESS) && !ack_hit &&
                       (cnt_q == 16'(TIMEOUT - 1));
`else
  // Without the watchdog ACCESS waits forever; TIMEOUT has no effect here.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (req) state_d = dec_valid ? ST_ACCESS : ST_ERR;
      ST_ACCESS: if (ack_hit || timeout_hit) state_d = ST_DONE;
      ST_ERR:    state_d = ST_DONE;
      ST_DONE:   state_d = ST_HOLD;
      ST_HOLD:   if (!req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register plus request latch, strobe register and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      m_data_q   <= '0;
      err_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      // Strobe rises one cycle into ACCESS and drops on the edge that leaves it.
      strobe_q <= (state_q == ST_ACCESS) && (state_d == ST_ACCESS);
      if (state_q == ST_IDLE && req) begin
        addr_q <= m_addr_i;
        data_q <= m_data_i;
        sel_q  <= m_sel_i;
        we_q   <= m_we_i;
        idx_q  <= dec_idx;
      end
      if (state_q == ST_ERR || timeout_hit) begin
        m_data_q   <= ERR_DATA;
        err_addr_q <= addr_q;
        err_q      <= 1'b1;
      end else if (ack_hit) begin
        m_data_q <= we_q ? '0 : rdata_sel;
        err_q    <= 1'b0;
      end
    end
  end

  // Only the selected slot sees a strobe; address, data and size go to all.
  always_comb begin
    s_rd_o = '0;
    s_we_o = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (32'(idx_q) == 32'(k)) begin
        s_rd_o[k] = strobe_q & ~we_q;
        s_we_o[k] = strobe_q &  we_q;
      end
    end
  end

  assign s_addr_o   = {N_SLAVES{addr_q}};
  assign s_data_o   = {N_SLAVES{data_q}};
  assign s_sel_o    = {N_SLAVES{sel_q}};
  assign m_ack_o    = (state_q == ST_DONE);
  assign err_o      = (state_q == ST_DONE) && err_q;
  assign m_data_o   = m_data_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_periph_bus.sv
// Bench for periph_bus: directed vector table, hand sequences for hold and
// mid-transaction reset, randomized transactions against a rule-level model,
// and watchdog cases when PERIPH_BUS_TIMEOUT_EN is defined.
module tb_periph_bus;
  localparam int          N   = 4;
  localparam int          T   = 255;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [31:0]    m_addr_i = '0, m_data_i = '0, m_data_o, err_addr_o;
  logic [1:0]     m_sel_i = '0;
  logic           m_rd_i = 1'b0, m_we_i = 1'b0, m_ack_o, err_o;
  logic [32*N-1:0] s_addr_o, s_data_o, s_data_i = '0;
  logic [2*N-1:0] s_sel_o;
  logic [N-1:0]   s_rd_o, s_we_o, s_ack_i;

  int checks = 0, failures = 0;

  periph_bus dut (
    .clk(clk), .rst(rst), .m_addr_i(m_addr_i), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_sel_i(m_sel_i), .m_rd_i(m_rd_i), .m_we_i(m_we_i),
    .m_ack_o(m_ack_o), .s_addr_o(s_addr_o), .s_data_o(s_data_o),
    .s_data_i(s_data_i), .s_sel_o(s_sel_o), .s_rd_o(s_rd_o), .s_we_o(s_we_o),
    .s_ack_i(s_ack_i), .err_o(err_o), .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  // Slave models: target acks once its strobe has been high s_dly cycles;
  // non-target slots may raise stray acks that must be ignored.
  int          tgt = 0, s_dly = 0;
  logic [N-1:0] noise = '0;
  int          hi_cnt [N] = '{default: 0};
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [1:0]  exp_sel = '0;

  always @(posedge clk)
    for (int k = 0; k < N; k++)
      hi_cnt[k] <= (s_rd_o[k] | s_we_o[k]) ? hi_cnt[k] + 1 : 0;

  always_comb begin
    s_ack_i = '0;
    for (int k = 0; k < N; k++)
      if (s_rd_o[k] | s_we_o[k]) s_ack_i[k] = (hi_cnt[k] >= s_dly);
      else                       s_ack_i[k] = (k != tgt) && noise[k];
  end

  // Bus monitor: cumulative strobe cycles, ack pulses and bus violations.
  int rd_cnt = 0, we_cnt = 0, ack_cnt = 0, bus_bad = 0;
  always @(negedge clk) begin
    int bad;
    bad = 0;
    for (int k = 0; k < N; k++) begin
      if ((s_rd_o[k] | s_we_o[k]) && k != tgt) bad++;
      if ((s_rd_o[k] | s_we_o[k]) && k == tgt &&
          (s_addr_o[32*k +: 32] !== exp_addr || s_data_o[32*k +: 32] !== exp_wdata ||
           s_sel_o[2*k +: 2] !== exp_sel)) bad++;
    end
    rd_cnt  <= rd_cnt + $countones(s_rd_o);
    we_cnt  <= we_cnt + $countones(s_we_o);
    ack_cnt <= ack_cnt + int'(m_ack_o);
    bus_bad <= bus_bad + bad;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input string nm, input logic [31:0] addr, wdata,
                         input logic [1:0] sel, input logic rd, we, input int dly,
                         input logic [31:0] rdata, input int hold,
                         input logic [31:0] x_data, input logic x_err,
                         input logic [31:0] x_eaddr, input int x_lat, input int x_stb);
    int n, rd0, we0, ack0, bb0;
    bit got;
    @(negedge clk);
    tgt   = int'(addr[15:12]);
    s_dly = dly;
    noise = N'($urandom);
    for (int k = 0; k < N; k++) s_data_i[32*k +: 32] = $urandom;
    if (tgt < N) s_data_i[32*tgt +: 32] = rdata;
    exp_addr = addr; exp_wdata = wdata; exp_sel = sel;
    rd0 = rd_cnt; we0 = we_cnt; ack0 = ack_cnt; bb0 = bus_bad;
    m_addr_i = addr; m_data_i = wdata; m_sel_i = sel; m_rd_i = rd; m_we_i = we;
    got = 0; n = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_ack_o) begin got = 1; n = i; break; end
    end
    chk({nm, " latency"}, 32'(n), 32'(x_lat));
    chk({nm, " data"}, m_data_o, x_data);
    chk({nm, " err"}, 32'(err_o), 32'(x_err));
    chk({nm, " err_addr"}, err_addr_o, x_eaddr);
    repeat (hold) @(posedge clk);
    @(negedge clk);
    m_rd_i = 1'b0; m_we_i = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    chk({nm, " ack_pulses"}, 32'(ack_cnt - ack0), 32'(got ? 1 : 0));
    chk({nm, " rd_strobes"}, 32'(rd_cnt - rd0), 32'(we ? 0 : x_stb));
    chk({nm, " we_strobes"}, 32'(we_cnt - we0), 32'(we ? x_stb : 0));
    chk({nm, " bus"}, 32'(bus_bad - bb0), 32'd0);
  endtask

  typedef struct {
    string       nm;
    logic [31:0] addr, wdata;
    logic [1:0]  sel;
    logic        rd, we;
    int          dly;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] x_data;
    logic        x_err;
    logic [31:0] x_eaddr;
    int          x_lat, x_stb;
  } vec_t;

  vec_t vt [6];
  logic [31:0] model_eaddr;

  initial begin
    vt[0] = '{"word_rd_s1",   32'h00001004, 32'h0,        2'b10, 1, 0, 3, 32'h12345678, 5,
              32'h12345678, 0, 32'h0,        5, 4};
    vt[1] = '{"byte_wr_s3",   32'h000030AC, 32'h000000A5, 2'b00, 0, 1, 1, 32'h0,        0,
              32'h0,        0, 32'h0,        3, 2};
    vt[2] = '{"unmapped_rd",  32'h00005000, 32'h0,        2'b10, 1, 0, 0, 32'h0,        0,
              ERR,          1, 32'h00005000, 1, 0};
    vt[3] = '{"half_rd_s0",   32'h00000002, 32'h0,        2'b01, 1, 0, 0, 32'hCAFEF00D, 1,
              32'hCAFEF00D, 0, 32'h00005000, 2, 1};
    vt[4] = '{"rdwe_is_wr",   32'h00002010, 32'h11112222, 2'b10, 1, 1, 2, 32'h77778888, 0,
              32'h0,        0, 32'h00005000, 4, 3};
    vt[5] = '{"unmapped_top", 32'hFFFFF000, 32'h9,        2'b00, 0, 1, 0, 32'h0,        2,
              ERR,          1, 32'hFFFFF000, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst m_ack", 32'(m_ack_o), 0);
    chk("rst m_data", m_data_o, 0);
    chk("rst err", 32'(err_o), 0);
    chk("rst err_addr", err_addr_o, 0);
    chk("rst strobes", 32'({s_rd_o, s_we_o}), 0);
    chk("rst s_addr", 32'(|s_addr_o), 0);
    chk("rst s_data", 32'(|s_data_o), 0);
    chk("rst s_sel", 32'(s_sel_o), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i])
      run_txn(vt[i].nm, vt[i].addr, vt[i].wdata, vt[i].sel, vt[i].rd, vt[i].we,
              vt[i].dly, vt[i].rdata, vt[i].hold, vt[i].x_data, vt[i].x_err,
              vt[i].x_eaddr, vt[i].x_lat, vt[i].x_stb);

    // Reset while a read strobe is up on slot 2.
    begin
      int ack0;
      bit got;
      @(negedge clk);
      tgt = 2; s_dly = 50; noise = '0;
      exp_addr = 32'h00002000; exp_wdata = 32'h0; exp_sel = 2'b10;
      ack0 = ack_cnt;
      m_addr_i = 32'h00002000; m_data_i = 32'h0; m_sel_i = 2'b10; m_rd_i = 1'b1;
      got = 0;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (s_rd_o[2]) begin got = 1; break; end
      end
      chk("rst_mid strobe_seen", 32'(got), 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_mid s_rd", 32'(s_rd_o), 0);
      chk("rst_mid m_ack", 32'(m_ack_o), 0);
      @(negedge clk);
      rst = 1'b0; m_rd_i = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_mid no_ack", 32'(ack_cnt - ack0), 0);
    end
    run_txn("after_rst_rd", 32'h00002040, 32'h0, 2'b10, 1, 0, 1, 32'h0BADF00D, 0,
            32'h0BADF00D, 0, 32'h0, 3, 2);
    model_eaddr = 32'h0;

    // Randomized transactions against the rule-level model.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] addr, wdata, rdata, x_data;
      logic [1:0]  sel;
      int          op, dly, idx, lat, stb;
      logic        x_err;
      idx   = $urandom_range(0, 7);
      addr  = (32'(idx) << 12) | ($urandom & 32'hFFFF0FFF);
      wdata = $urandom; rdata = $urandom;
      sel   = 2'($urandom_range(0, 2));
      op    = $urandom_range(1, 3);
      dly   = $urandom_range(0, 6);
      idx   = int'((addr >> 12) % 16);
      if (idx < N) begin
        x_data = (op >= 2) ? 32'h0 : rdata;
        x_err  = 1'b0;
        lat    = dly + 2;
        stb    = dly + 1;
      end else begin
        x_data      = ERR;
        x_err       = 1'b1;
        lat         = 1;
        stb         = 0;
        model_eaddr = addr;
      end
      run_txn("rand", addr, wdata, sel, op[0], op[1], dly, rdata, $urandom_range(0, 3),
              x_data, x_err, model_eaddr, lat, stb);
    end

`ifdef PERIPH_BUS_TIMEOUT_EN
    run_txn("timeout", 32'h00000100, 32'h0, 2'b10, 1, 0, 1000, 32'h55AA55AA, 0,
            ERR, 1, 32'h00000100, T, T - 1);
    run_txn("ack_at_limit", 32'h00000200, 32'h0, 2'b10, 1, 0, T - 2, 32'h600DCAFE, 0,
            32'h600DCAFE, 0, 32'h00000100, T, T - 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
